// File: rtl/key_click_decoder_pkg.sv
// Shared definitions for the key click decoder: FSM states, click-count codes
// and the default gap window.
package key_click_decoder_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } kcd_state_t;

  localparam logic [1:0] CLICK_NONE   = 2'd0;
  localparam logic [1:0] CLICK_SINGLE = 2'd1;
  localparam logic [1:0] CLICK_DOUBLE = 2'd2;
  localparam logic [1:0] CLICK_TRIPLE = 2'd3;

  // 40 ticks of 8 ms = 320 ms between pulses of one gesture
  localparam int WINDOW_TICKS_DEF = 40;

  // A gesture closes as soon as this many clicks have been seen
  localparam int MAX_CLICKS = 3;

endpackage

// File: rtl/key_click_decoder_if.sv
// Key-pulse input and gesture outputs of the click decoder.
// master = producer of key pulses / consumer of gestures, slave = decoder.
interface key_click_decoder_if;
  logic       key_pulse;
  logic       single_click;
  logic       double_click;
  logic       triple_click;
  logic [1:0] click_count;
  logic       busy;

  modport master (
    output key_pulse,
    input  single_click,
    input  double_click,
    input  triple_click,
    input  click_count,
    input  busy
  );

  modport slave (
    input  key_pulse,
    output single_click,
    output double_click,
    output triple_click,
    output click_count,
    output busy
  );
endinterface

// File: rtl/key_click_decoder.sv
// Groups debounced key-release pulses into gestures and classifies each as a
// single, double or triple click.
//
// state      | meaning
// ST_IDLE    | no gesture in progress, waiting for the first pulse
// ST_COLLECT | gesture open, counting clicks and the gap since the last one
module key_click_decoder
  import key_click_decoder_pkg::*;
#(
  parameter int WINDOW_TICKS = WINDOW_TICKS_DEF
) (
  input  logic               clk_8ms,
  input  logic               rst_n,
  input  logic               rst_sync,
  key_click_decoder_if.slave bus
);

  localparam int              GAP_W     = $clog2(WINDOW_TICKS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(WINDOW_TICKS - 1);
  localparam logic [1:0]       CLICK_MAX = 2'(MAX_CLICKS);

  kcd_state_t       r_state;
  logic [1:0]       r_clicks;
  logic [GAP_W-1:0] r_gap;
  logic             r_single;
  logic             r_double;
  logic             r_triple;
  logic [1:0]       r_count;
  logic             r_busy;

  logic [1:0]       w_clicks_inc;
  logic             w_fire;
  logic [1:0]       w_fire_count;

  // Decide whether this edge closes the gesture; a pulse on the last gap tick wins
  always_comb begin
    w_clicks_inc = r_clicks + 2'd1;
    w_fire       = 1'b0;
    w_fire_count = CLICK_NONE;
    if (r_state == ST_COLLECT) begin
      if (bus.key_pulse) begin
        if (w_clicks_inc == CLICK_MAX) begin
          w_fire       = 1'b1;
          w_fire_count = w_clicks_inc;
        end
      end else if (r_gap == GAP_LAST) begin
        w_fire       = 1'b1;
        w_fire_count = r_clicks;
      end
    end
  end

  // Gesture FSM with registered classification pulses, held count and busy
  always_ff @(posedge clk_8ms or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_clicks <= 2'd0;
      r_gap    <= '0;
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_triple <= 1'b0;
      r_count  <= CLICK_NONE;
      r_busy   <= 1'b0;
    end else if (rst_sync) begin
      r_state  <= ST_IDLE;
      r_clicks <= 2'd0;
      r_gap    <= '0;
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_triple <= 1'b0;
      r_count  <= CLICK_NONE;
      r_busy   <= 1'b0;
    end else begin
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_triple <= 1'b0;
      if (w_fire) begin
        r_single <= (w_fire_count == CLICK_SINGLE);
        r_double <= (w_fire_count == CLICK_DOUBLE);
        r_triple <= (w_fire_count == CLICK_TRIPLE);
        r_count  <= w_fire_count;
      end
      if (r_state == ST_IDLE) begin
        if (bus.key_pulse) begin
          r_state  <= ST_COLLECT;
          r_clicks <= 2'd1;
          r_gap    <= '0;
          r_busy   <= 1'b1;
        end else begin
          r_busy   <= 1'b0;
        end
      end else begin
        if (w_fire) begin
          r_state  <= ST_IDLE;
          r_clicks <= 2'd0;
          r_gap    <= '0;
          r_busy   <= 1'b0;
        end else if (bus.key_pulse) begin
          r_clicks <= w_clicks_inc;
          r_gap    <= '0;
        end else begin
          r_gap    <= r_gap + 1'b1;
        end
      end
    end
  end

  assign bus.single_click = r_single;
  assign bus.double_click = r_double;
  assign bus.triple_click = r_triple;
  assign bus.click_count  = r_count;
  assign bus.busy         = r_busy;

endmodule

// File: doc/key_click_decoder.md
Name: key_click_decoder

Overview:
- Consumes the one-cycle, debounced key-release pulses produced by the per-key handler in the 8 ms clock domain.
- Groups pulses that arrive within a gap window into one gesture and classifies it as a single, double or triple click.
- Emits one classification pulse per gesture plus a held click count. The mode/menu control logic uses these as user commands.

Parameters:
- WINDOW_TICKS, 40, maximum gap between consecutive pulses of one gesture, in clk_8ms cycles (40 = 320 ms); must be >= 2.
- MAX_CLICKS, 3, pulse count that closes a gesture immediately; fixed at 3 for this revision.

Ports:
- clk_8ms  in  1  8 ms tick clock
- rst_n  in  1  asynchronous active-low reset
- rst_sync  in  1  synchronous clear, same semantics as in the key handler
- key_pulse  in  1  debounced key event, high for exactly one cycle per release
- single_click  out  1  one-cycle pulse: gesture of 1 click
- double_click  out  1  one-cycle pulse: gesture of 2 clicks
- triple_click  out  1  one-cycle pulse: gesture of 3 clicks
- click_count  out  2  count of the last classified gesture, held until the next one
- busy  out  1  high while a gesture is being collected

Behaviour:
- Reset: rst_n is asynchronous and active-low, on clock clk_8ms. All outputs reset to 0, state goes to IDLE, internal counters clear to 0.
- rst_sync has priority over all other inputs. At the next edge it forces the same values as reset. Any partial gesture is discarded with no output.
- State machine: IDLE, COLLECT.
- IDLE: busy=0. When key_pulse=1 at an edge, go to COLLECT with clicks=1 and gap=0.
- COLLECT: busy=1.
  - key_pulse=1: clicks+1 and gap=0. If clicks reaches MAX_CLICKS, classify at this edge and go to IDLE.
  - key_pulse=0 and gap < WINDOW_TICKS-1: gap+1.
  - key_pulse=0 and gap == WINDOW_TICKS-1: classify at this edge and go to IDLE.
- Boundary: if key_pulse=1 on the same edge where gap == WINDOW_TICKS-1, the pulse wins. It is counted in the current gesture.
- Classification: at the deciding edge, register exactly one of single/double/triple_click high for one cycle, set click_count = clicks, and set busy=0.
- Latency:
  - 1- or 2-click gesture: output is visible for the cycle following edge n+WINDOW_TICKS, where n is the edge that sampled the last pulse.
  - 3-click gesture: output is visible the cycle after the third pulse's edge.
- A key_pulse in the cycle where a classification output is high is handled by IDLE. It starts a new gesture and does not affect the emitted pulse.
- Widths:
  - gap counter: clog2(WINDOW_TICKS) bits.
  - clicks: 2 bits; it never exceeds MAX_CLICKS.
- Classification pulses are mutually exclusive.
- Async reset mid-gesture: immediate clear, no output.

Decomposition:
- Shared key package:
  - state encoding: IDLE, COLLECT
  - click-count codes: CLICK_NONE=0, CLICK_SINGLE=1, CLICK_DOUBLE=2, CLICK_TRIPLE=3
  - default WINDOW_TICKS constant
- No sub-module: the gap counter and FSM are small enough to stay in one module.

Test Plan (WINDOW_TICKS=40; "cycle k" = the cycle after edge k):
- Pulse at 10 -> busy high from cycle 10 to cycle 49; single_click high only in cycle 50; click_count=1 from cycle 50.
- Pulses at 10 and 30 -> double_click high only in cycle 70; no single_click at any time; click_count=2.
- Pulses at 10, 20, 30 -> triple_click high in cycle 30; busy low from cycle 30; no further output through cycle 80.
- Pulses at 10 and 50 -> treated as a double, double_click in cycle 90.
- Pulses at 10 and 51 -> single_click in cycle 50, then a new gesture with single_click in cycle 91.
- Pulse at 10, rst_sync at 25 -> busy low from cycle 25, no click outputs, click_count holds 0. Repeat with rst_n low at cycle 25 -> outputs clear immediately.
